// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and defaults for seq_alu
package alu_pkg;

  localparam int OP_LEN_DEF = 4;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_PASSA = 4'b0011;
  localparam logic [3:0] OP_PASSB = 4'b0100;
  localparam logic [3:0] OP_ZERO  = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_SHL   = 4'b1010;
  localparam logic [3:0] OP_SHR   = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - start/busy/done request bus between control unit and seq_alu
interface seq_alu_if #(
  parameter int DATA_LEN = 16,
  parameter int OP_LEN   = 4
);
  logic                start;
  logic [OP_LEN-1:0]   select;
  logic [DATA_LEN-1:0] A;
  logic [DATA_LEN-1:0] B;
  logic [DATA_LEN-1:0] out;
  logic                z_flag;
  logic                n_flag;
  logic                c_flag;
  logic                v_flag;
  logic                busy;
  logic                done;
  logic                finish;

  modport master (
    output start, select, A, B,
    input  out, z_flag, n_flag, c_flag, v_flag, busy, done, finish
  );

  modport slave (
    input  start, select, A, B,
    output out, z_flag, n_flag, c_flag, v_flag, busy, done, finish
  );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add unsigned multiplier, one multiplier bit per cycle
module seq_multiplier #(
  parameter int DATA_LEN = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_LEN-1:0]   a,
  input  logic [DATA_LEN-1:0]   b,
  output logic                  done,
  output logic [2*DATA_LEN-1:0] product
);
  localparam int CW = $clog2(DATA_LEN);
  localparam logic [CW-1:0] LAST = CW'(DATA_LEN - 1);

  logic                  running;
  logic [CW-1:0]         cnt;
  logic [2*DATA_LEN-1:0] mcand;
  logic [DATA_LEN-1:0]   mplier;
  logic [2*DATA_LEN-1:0] acc;
  logic [2*DATA_LEN-1:0] acc_nxt;

  // Partial-sum for the current bit; exposed as product so the final sum is usable on the last edge
  always_comb begin
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
  end

  assign done    = running && (cnt == LAST);
  assign product = acc_nxt;

  // Operand latch on start, then one shift-add step per cycle for DATA_LEN cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= {{DATA_LEN{1'b0}}, a};
      mplier  <= b;
      acc     <= '0;
    end else if (running) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with start/busy/done handshake and iterative multiply
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_LEN = 16,
  parameter int OP_LEN   = OP_LEN_DEF
) (
  input logic       clk,
  input logic       reset,
  seq_alu_if.slave  bus
);
  state_t                state, state_nxt;
  logic [OP_LEN-1:0]     op;
  logic [DATA_LEN:0]     sum, diff;
  logic [DATA_LEN-1:0]   sc_res, res;
  logic                  sc_c, sc_v, sc_wr;
  logic                  c_res, v_res, wr_en, set_fin, done_nxt, mul_start, mul_done;
  logic [2*DATA_LEN-1:0] product;
  logic [DATA_LEN-1:0]   out_q;
  logic                  z_q, n_q, c_q, v_q, done_q, fin_q;

  assign op = bus.select;

  seq_multiplier #(.DATA_LEN(DATA_LEN)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.A),
    .b       (bus.B),
    .done    (mul_done),
    .product (product)
  );

  // Single-cycle datapath: result, carry and overflow for every non-multiply opcode
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_wr  = 1'b1;
    sum    = {1'b0, bus.A} + {1'b0, bus.B};
    diff   = {1'b0, bus.A} - {1'b0, bus.B};
    case (op)
      OP_ADD: begin
        sc_res = sum[DATA_LEN-1:0];
        sc_c   = sum[DATA_LEN];
        sc_v   = (bus.A[DATA_LEN-1] == bus.B[DATA_LEN-1]) && (sum[DATA_LEN-1] != bus.A[DATA_LEN-1]);
      end
      OP_SUB: begin
        sc_res = diff[DATA_LEN-1:0];
        sc_c   = ~diff[DATA_LEN];
        sc_v   = (bus.A[DATA_LEN-1] != bus.B[DATA_LEN-1]) && (diff[DATA_LEN-1] != bus.A[DATA_LEN-1]);
      end
      OP_PASSA: sc_res = bus.A;
      OP_PASSB: sc_res = bus.B;
      OP_ZERO:  sc_res = '0;
      OP_AND:   sc_res = bus.A & bus.B;
      OP_OR:    sc_res = bus.A | bus.B;
      OP_XOR:   sc_res = bus.A ^ bus.B;
      OP_SHL: begin
        sc_res = {bus.A[DATA_LEN-2:0], 1'b0};
        sc_c   = bus.A[DATA_LEN-1];
      end
      OP_SHR: begin
        sc_res = {1'b0, bus.A[DATA_LEN-1:1]};
        sc_c   = bus.A[0];
      end
      default: sc_wr = 1'b0;
    endcase
  end

  // FSM next state and per-edge write/done/halt decisions
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    wr_en     = 1'b0;
    set_fin   = 1'b0;
    done_nxt  = 1'b0;
    res       = sc_res;
    c_res     = sc_c;
    v_res     = sc_v;
    case (state)
      S_IDLE: begin
        if (bus.start && !fin_q) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_nxt = S_MUL_RUN;
          end else if (op == OP_HALT) begin
            set_fin  = 1'b1;
            done_nxt = 1'b1;
          end else begin
            wr_en     = sc_wr;
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_MUL_RUN: begin
        if (mul_done) begin
          wr_en     = 1'b1;
          res       = product[DATA_LEN-1:0];
          c_res     = |product[2*DATA_LEN-1:DATA_LEN];
          v_res     = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Result/flag registers hold until the next result-writing op; done is a one-cycle pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (set_fin) fin_q <= 1'b1;
      if (wr_en) begin
        out_q <= res;
        z_q   <= (res == '0);
        n_q   <= res[DATA_LEN-1];
        c_q   <= c_res;
        v_q   <= v_res;
      end
    end
  end

  assign bus.out    = out_q;
  assign bus.z_flag = z_q;
  assign bus.n_flag = n_q;
  assign bus.c_flag = c_q;
  assign bus.v_flag = v_q;
  assign bus.busy   = (state == S_MUL_RUN);
  assign bus.done   = done_q;
  assign bus.finish = fin_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized self-checking bench for seq_alu against an arithmetic reference model
module tb_seq_alu;
  localparam int N    = 16;
  localparam int M    = 1 << N;
  localparam int HALF = 1 << (N - 1);

  typedef struct {
    int unsigned res;
    bit          wr;
    bit          c;
    bit          v;
    bit          halt;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int unsigned e_out = 0;
  bit e_z = 0, e_n = 0, e_c = 0, e_v = 0, e_fin = 0;

  seq_alu_if #(.DATA_LEN(N), .OP_LEN(4)) bus ();

  seq_alu #(.DATA_LEN(N), .OP_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int unsigned x);
    return (x >= HALF) ? int'(x) - M : int'(x);
  endfunction

  function automatic exp_t model(input int op, input int unsigned a, input int unsigned b);
    exp_t   e;
    longint p;
    int     s;
    e.wr = 1; e.c = 0; e.v = 0; e.halt = 0; e.lat = 1; e.res = 0;
    case (op)
      0: begin
        p = longint'(a) + longint'(b);
        e.res = int'(p % M); e.c = (p >= M);
        s = to_signed(a) + to_signed(b);
        e.v = (s >= HALF) || (s < -HALF);
      end
      1: begin
        p = longint'(a) - longint'(b) + M;
        e.res = int'(p % M); e.c = (a >= b);
        s = to_signed(a) - to_signed(b);
        e.v = (s >= HALF) || (s < -HALF);
      end
      2: begin
        p = longint'(a) * longint'(b);
        e.res = int'(p % M); e.c = (p >= M); e.lat = N + 1;
      end
      3:  e.res = a;
      4:  e.res = b;
      5:  e.res = 0;
      6:  begin e.wr = 0; e.halt = 1; end
      7:  e.res = a & b;
      8:  e.res = a | b;
      9:  e.res = a ^ b;
      10: begin e.res = (a * 2) % M; e.c = (a >= HALF); end
      11: begin e.res = a / 2; e.c = (a % 2 == 1); end
      default: e.wr = 0;
    endcase
    return e;
  endfunction

  task automatic check_held(input string tag);
    check({tag, ".out"}, bus.out, e_out);
    check({tag, ".z"}, bus.z_flag, e_z);
    check({tag, ".n"}, bus.n_flag, e_n);
    check({tag, ".c"}, bus.c_flag, e_c);
    check({tag, ".v"}, bus.v_flag, e_v);
    check({tag, ".fin"}, bus.finish, e_fin);
  endtask

  task automatic run_op(input int op, input int unsigned a, input int unsigned b, input bit noise);
    exp_t e;
    int   n;
    bit   got;
    e = model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.select = 4'(op); bus.A = 16'(a); bus.B = 16'(b);
    n = 0; got = 0;
    while (n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.done) begin got = 1; break; end
      if (noise && bus.busy) begin
        bus.start = 1'($urandom); bus.A = 16'($urandom); bus.B = 16'($urandom);
        bus.select = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check($sformatf("op%0d.latency", op), got ? n : -1, e.lat);
    if (e.wr) begin
      e_out = e.res; e_z = (e.res == 0); e_n = (e.res >= HALF); e_c = e.c; e_v = e.v;
    end
    if (e.halt) e_fin = 1;
    check_held($sformatf("op%0d", op));
    @(negedge clk);
    check($sformatf("op%0d.done_pulse", op), bus.done, 0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    int unsigned a, b;
    int op, dn;
    bus.start = 1'b0; bus.select = '0; bus.A = '0; bus.B = '0;

    #2 reset = 1'b1;
    #1;
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check_held("rst");
    clk_en = 1'b1;
    #17 reset = 1'b0;

    run_op(0, 16'h0003, 16'h0004, 0);
    run_op(0, 16'hFFFF, 16'h0001, 0);
    run_op(0, 16'h7FFF, 16'h0001, 0);
    run_op(1, 5, 5, 0);
    run_op(1, 3, 5, 0);
    run_op(1, 16'h8000, 16'h0001, 0);
    run_op(2, 300, 300, 1);
    run_op(2, 0, 16'hBEEF, 1);
    run_op(15, 16'h1234, 16'h5678, 0);
    run_op(10, 16'h8001, 0, 0);
    run_op(11, 16'h0003, 0, 0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      if (op == 6) op = 5;
      case ($urandom_range(0, 3))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        default: a = $urandom_range(0, M - 1);
      endcase
      b = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, M - 1);
      run_op(op, a, b, 1'($urandom));
    end

    @(negedge clk);
    bus.start = 1'b1; bus.select = 4'd2; bus.A = 16'd300; bus.B = 16'd300;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort.busy_before", bus.busy, 1);
    #1 reset = 1'b1;
    #1;
    check("abort.busy", bus.busy, 0);
    check("abort.done", bus.done, 0);
    e_out = 0; e_z = 0; e_n = 0; e_c = 0; e_v = 0; e_fin = 0;
    check_held("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    count_dones(24, dn);
    check("abort.no_done", dn, 0);
    run_op(0, 1, 1, 0);

    run_op(6, 0, 0, 0);
    check("halt.finish", bus.finish, 1);
    @(negedge clk);
    bus.start = 1'b1; bus.select = 4'd0; bus.A = 16'd9; bus.B = 16'd9;
    count_dones(20, dn);
    check("halt.no_done", dn, 0);
    check_held("halt.held");
    #1 reset = 1'b1;
    #1;
    check("halt.rst_finish", bus.finish, 0);
    #10 reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
